// File: rtl/axis_pattern_src.sv
// AXI4-Stream test-pattern master: framed counter/LFSR/walking-one/alternating
// traffic with runtime frame length, gap, frame count and start/stop control.
module axis_pattern_src #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = DATA_W / 8,
    parameter int USER_W = 1,
    parameter int LEN_W  = 16,
    parameter int GAP_W  = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [LEN_W-1:0]  cfg_frame_beats,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic [15:0]       cfg_num_frames,
    input  logic [1:0]        cfg_mode,
    input  logic              start,
    input  logic              stop,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic [USER_W-1:0] m_axis_tuser,
    output logic              busy,
    output logic              done,
    output logic [31:0]       frames_sent
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam int          REP       = (DATA_W + 31) / 32;

    state_t              r_state;
    logic                r_valid;
    logic [DATA_W-1:0]   r_data;
    logic                r_last;
    logic                r_user;
    logic                r_busy;
    logic                r_done;
    logic [31:0]         r_frames_sent;
    logic [31:0]         r_lfsr;
    logic [15:0]         r_fid;
    logic [15:0]         r_run;
    logic [LEN_W-1:0]    r_beat;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic                r_stop;
    logic [LEN_W-1:0]    r_beats;
    logic [GAP_W-1:0]    r_gap;
    logic [15:0]         r_nframes;
    logic [1:0]          r_mode;

    logic                w_hs;
    logic [31:0]         w_lfsr_nx;
    logic [LEN_W-1:0]    w_last_idx;
    logic [LEN_W-1:0]    w_beat_nx;
    logic [15:0]         w_fid_nx;
    logic [15:0]         w_run_nx;
    logic                w_stop;
    logic                w_end;

    function automatic logic [DATA_W-1:0] pat(
        input logic [1:0]       m,
        input logic [LEN_W-1:0] b,
        input logic [15:0]      f,
        input logic [31:0]      l
    );
        logic [DATA_W-1:0] d;
        logic [31:0]       bw;
        bw = 32'(b);
        unique case (m)
            2'd0: d = DATA_W'({f, bw[15:0]});
            2'd1: d = DATA_W'({REP{l}});
            2'd2: d = DATA_W'(1) << (bw % 32'(DATA_W));
            default: d = {KEEP_W{bw[0] ? 8'h5A : 8'hA5}};
        endcase
        return d;
    endfunction

    assign w_hs       = r_valid & m_axis_tready;
    assign w_lfsr_nx  = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
    assign w_last_idx = (r_beats == '0) ? '0 : r_beats - 1'b1;
    assign w_beat_nx  = r_beat + 1'b1;
    assign w_fid_nx   = r_fid + 16'd1;
    assign w_run_nx   = r_run + 16'd1;
    assign w_stop     = r_stop | stop;
    assign w_end      = ((r_nframes != 16'd0) && (w_run_nx == r_nframes)) | w_stop;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state       <= S_IDLE;
            r_valid       <= 1'b0;
            r_data        <= '0;
            r_last        <= 1'b0;
            r_user        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_frames_sent <= '0;
            r_lfsr        <= 32'h0000_0001;
            r_fid         <= '0;
            r_run         <= '0;
            r_beat        <= '0;
            r_gap_cnt     <= '0;
            r_stop        <= 1'b0;
            r_beats       <= '0;
            r_gap         <= '0;
            r_nframes     <= '0;
            r_mode        <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_stop <= 1'b0;
                    if (start) begin
                        r_beats   <= cfg_frame_beats;
                        r_gap     <= cfg_gap;
                        r_nframes <= cfg_num_frames;
                        r_mode    <= cfg_mode;
                        r_stop    <= stop;
                        r_beat    <= '0;
                        r_fid     <= '0;
                        r_run     <= '0;
                        r_valid   <= 1'b1;
                        r_data    <= pat(cfg_mode, '0, '0, r_lfsr);
                        r_user    <= 1'b1;
                        r_last    <= (cfg_frame_beats <= 1);
                        r_busy    <= 1'b1;
                        r_state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_stop <= w_stop;
                    if (w_hs) begin
                        r_lfsr <= w_lfsr_nx;
                        if (!r_last) begin
                            r_beat <= w_beat_nx;
                            r_data <= pat(r_mode, w_beat_nx, r_fid, w_lfsr_nx);
                            r_user <= 1'b0;
                            r_last <= (w_beat_nx == w_last_idx);
                        end else begin
                            r_frames_sent <= r_frames_sent + 32'd1;
                            r_fid         <= w_fid_nx;
                            r_run         <= w_run_nx;
                            if (w_end) begin
                                r_valid <= 1'b0;
                                r_last  <= 1'b0;
                                r_user  <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else if (r_gap == '0) begin
                                r_beat <= '0;
                                r_data <= pat(r_mode, '0, w_fid_nx, w_lfsr_nx);
                                r_user <= 1'b1;
                                r_last <= (w_last_idx == '0);
                            end else begin
                                r_valid   <= 1'b0;
                                r_last    <= 1'b0;
                                r_user    <= 1'b0;
                                r_gap_cnt <= r_gap;
                                r_state   <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    r_stop <= w_stop;
                    if (r_gap_cnt <= 1) begin
                        if (w_stop) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_valid <= 1'b1;
                            r_beat  <= '0;
                            r_data  <= pat(r_mode, '0, r_fid, r_lfsr);
                            r_user  <= 1'b1;
                            r_last  <= (w_last_idx == '0);
                            r_state <= S_SEND;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_stop  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_axis_tvalid = r_valid;
    assign m_axis_tdata  = r_data;
    assign m_axis_tkeep  = '1;
    assign m_axis_tlast  = r_last;
    assign m_axis_tuser  = USER_W'(r_user);
    assign busy          = r_busy;
    assign done          = r_done;
    assign frames_sent   = r_frames_sent;

endmodule
